// File: rtl/yrv_tick_irq_if.sv
// Timer configuration and interrupt status bundle for yrv_tick_irq.
// Master side drives prescaler, channel controls, acks and mask.
// Slave side (the timer) returns pending, overrun and the ei_req line.
interface yrv_tick_irq_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 16
);
  logic [PRE_W-1:0]      prescale_div;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       ch_oneshot;
  logic [N_CH*CNT_W-1:0] ch_period;
  logic [N_CH-1:0]       ch_ack;
  logic [N_CH-1:0]       irq_mask;
  logic [N_CH-1:0]       irq_pending;
  logic [N_CH-1:0]       irq_overrun;
  logic                  ei_req;

  modport master (
    output prescale_div, ch_en, ch_oneshot, ch_period, ch_ack, irq_mask,
    input  irq_pending, irq_overrun, ei_req
  );

  modport slave (
    input  prescale_div, ch_en, ch_oneshot, ch_period, ch_ack, irq_mask,
    output irq_pending, irq_overrun, ei_req
  );
endinterface

// File: rtl/yrv_tick_irq.sv
// Multi-channel periodic/one-shot interrupt timer behind a shared prescaler.
// Latency: pending one edge after the hit tick, ei_req one edge after pending.
// No backpressure: events are sticky until acked; a repeat event sets overrun.
module yrv_tick_irq #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 16
) (
  input  logic           clk,
  input  logic           resetb,
  yrv_tick_irq_if.slave  tmr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] period  [N_CH];

  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  ovr_q, ovr_d;
  logic             ei_req_q, ei_req_d;

  // Prescaler: >= compare lets a smaller divider take effect immediately.
  always_comb begin
    tick      = (pre_cnt_q >= tmr.prescale_div);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
  end

  // Unpack per-channel terminal counts.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      period[i] = tmr.ch_period[i*CNT_W +: CNT_W];
    end
  end

  // Channel FSMs: next state, next count and hit strobe.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!tmr.ch_en[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
          end
          ST_RUN: begin
            if (tick) begin
              if (cnt_q[i] >= period[i]) begin
                hit[i]   = 1'b1;
                cnt_d[i] = '0;
                if (tmr.ch_oneshot[i]) state_d[i] = ST_DONE;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          ST_DONE: ;
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Sticky pending/overrun: a new hit always wins over a same-cycle ack.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < N_CH; i++) begin
      if (hit[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !tmr.ch_ack[i]) ovr_d[i] = 1'b1;
        else if (tmr.ch_ack[i])          ovr_d[i] = 1'b0;
      end else if (tmr.ch_ack[i]) begin
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end
    end
    ei_req_d = |(pend_q & tmr.irq_mask);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pre_cnt_q <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      ei_req_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      ei_req_q  <= ei_req_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign tmr.irq_pending = pend_q;
  assign tmr.irq_overrun = ovr_q;
  assign tmr.ei_req      = ei_req_q;

endmodule

// File: tb/tb_yrv_tick_irq.sv
// Directed self-checking bench for yrv_tick_irq.
// Inputs change #1 after rising edges; outputs are sampled there too.
// Every wait is bounded; timeouts count as failed comparisons.
module tb_yrv_tick_irq;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int PRE_W = 16;

  logic clk = 1'b0;
  logic resetb;
  int   n_checks = 0;
  int   n_fail   = 0;

  yrv_tick_irq_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) ifc ();

  yrv_tick_irq #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk    (clk),
    .resetb (resetb),
    .tmr    (ifc)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_period(input int ch, input int val);
    ifc.ch_period[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  // Steps until channel ch shows pending or max edges elapse; n = edges taken.
  task automatic wait_pend(input int ch, input int max, output int n);
    n = 0;
    while (!ifc.irq_pending[ch] && n < max) begin
      step(1);
      n++;
    end
  endtask

  int n;
  logic seen;

  initial begin
    ifc.prescale_div = '0;
    ifc.ch_en        = '0;
    ifc.ch_oneshot   = '0;
    ifc.ch_period    = '0;
    ifc.ch_ack       = '0;
    ifc.irq_mask     = '0;
    resetb           = 1'b1;
    #2 resetb = 1'b0;
    #1;
    check_eq("rst_pending", 32'(ifc.irq_pending), 32'h0);
    check_eq("rst_overrun", 32'(ifc.irq_overrun), 32'h0);
    check_eq("rst_ei_req",  32'(ifc.ei_req),      32'h0);
    step(3);
    resetb = 1'b1;
    step(2);

    // 125 Hz compatibility on ch0: hit 40000 cycles after enable edge.
    set_period(0, 39999);
    ifc.irq_mask  = 4'b0001;
    ifc.ch_en[0]  = 1'b1;
    step(1);                       // enable edge E
    step(39999);                   // E+39999
    check_eq("t1_pend_before", 32'(ifc.irq_pending[0]), 32'h0);
    step(1);                       // E+40000
    check_eq("t1_pend_hit",    32'(ifc.irq_pending[0]), 32'h1);
    check_eq("t1_ei_lag",      32'(ifc.ei_req),         32'h0);
    step(1);                       // E+40001, cnt=1
    check_eq("t1_ei_req",      32'(ifc.ei_req),         32'h1);
    check_eq("t1_ovr_first",   32'(ifc.irq_overrun[0]), 32'h0);
    // Shrink period to 9: cnt reaches 9 at E+40009, second hit at E+40010.
    set_period(0, 9);
    step(8);
    check_eq("t1_ovr_before",  32'(ifc.irq_overrun[0]), 32'h0);
    step(1);
    check_eq("t1_ovr_second",  32'(ifc.irq_overrun[0]), 32'h1);
    ifc.ch_en[0]  = 1'b0;
    ifc.ch_ack[0] = 1'b1;
    ifc.irq_mask  = '0;
    step(1);
    ifc.ch_ack[0] = 1'b0;
    check_eq("t1_ack_pend",    32'(ifc.irq_pending[0]), 32'h0);
    check_eq("t1_ack_ovr",     32'(ifc.irq_overrun[0]), 32'h0);
    step(1);
    check_eq("t1_ei_clear",    32'(ifc.ei_req),         32'h0);

    // Prescaled periodic: div=4, period=9 -> hits every 50 clk cycles.
    ifc.prescale_div = PRE_W'(4);
    ifc.ch_en[0]     = 1'b1;
    wait_pend(0, 200, n);
    check_eq("t2_first_hit",   32'(n < 200),            32'h1);
    ifc.ch_ack[0] = 1'b1;
    step(1);
    ifc.ch_ack[0] = 1'b0;
    check_eq("t2_ack_pend",    32'(ifc.irq_pending[0]), 32'h0);
    n = 1;
    while (!ifc.irq_pending[0] && n < 200) begin
      step(1);
      n++;
    end
    check_eq("t2_hit_spacing", 32'(n),                  32'd50);
    check_eq("t2_ovr",         32'(ifc.irq_overrun[0]), 32'h0);
    ifc.ch_en[0]     = 1'b0;
    ifc.ch_ack[0]    = 1'b1;
    ifc.prescale_div = '0;
    step(1);
    ifc.ch_ack[0] = 1'b0;

    // Simultaneous hit and ack, period=3: hits at E+4, E+8, E+12.
    set_period(0, 3);
    ifc.ch_en[0] = 1'b1;
    step(1);                       // E
    step(4);
    check_eq("t3_hit1",        32'(ifc.irq_pending[0]), 32'h1);
    step(4);
    check_eq("t3_ovr_set",     32'(ifc.irq_overrun[0]), 32'h1);
    step(3);                       // E+11
    ifc.ch_ack[0] = 1'b1;
    step(1);                       // E+12: hit with ack
    check_eq("t3_hitack_pend", 32'(ifc.irq_pending[0]), 32'h1);
    check_eq("t3_hitack_ovr",  32'(ifc.irq_overrun[0]), 32'h0);
    step(1);                       // E+13: ack without hit
    check_eq("t3_ack_clear",   32'(ifc.irq_pending[0]), 32'h0);
    ifc.ch_ack[0] = 1'b0;
    ifc.ch_en[0]  = 1'b0;
    step(1);

    // One-shot, period=5: single hit 6 cycles after enable, re-arm via IDLE.
    set_period(0, 5);
    ifc.ch_oneshot[0] = 1'b1;
    ifc.ch_en[0]      = 1'b1;
    step(1);
    step(5);
    check_eq("t4_pend_before", 32'(ifc.irq_pending[0]), 32'h0);
    step(1);
    check_eq("t4_pend_hit",    32'(ifc.irq_pending[0]), 32'h1);
    ifc.ch_ack[0] = 1'b1;
    step(1);
    ifc.ch_ack[0] = 1'b0;
    check_eq("t4_ack_pend",    32'(ifc.irq_pending[0]), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      seen = seen | ifc.irq_pending[0];
    end
    check_eq("t4_no_rehit",    32'(seen),               32'h0);
    ifc.ch_en[0] = 1'b0;
    step(1);
    ifc.ch_en[0] = 1'b1;
    step(1);
    step(5);
    check_eq("t4_rearm_before", 32'(ifc.irq_pending[0]), 32'h0);
    step(1);
    check_eq("t4_rearm_hit",   32'(ifc.irq_pending[0]), 32'h1);
    ifc.ch_en[0]      = 1'b0;
    ifc.ch_oneshot[0] = 1'b0;
    ifc.ch_ack[0]     = 1'b1;
    step(1);
    ifc.ch_ack[0] = 1'b0;

    // Multi-channel mask and period shrink.
    set_period(0, 7);
    set_period(1, 11);
    ifc.irq_mask = 4'b0010;
    ifc.ch_en    = 4'b0011;
    step(1);                       // E
    step(8);                       // E+8: ch0 hits, ch1 cnt=8
    check_eq("t5_pend_ch0",    32'(ifc.irq_pending),    32'h1);
    check_eq("t5_ei_masked0",  32'(ifc.ei_req),         32'h0);
    set_period(1, 2);
    step(1);                       // E+9: ch1 hits on shrunken period
    check_eq("t5_pend_shrink", 32'(ifc.irq_pending),    32'h3);
    check_eq("t5_ei_masked1",  32'(ifc.ei_req),         32'h0);
    step(1);                       // E+10
    check_eq("t5_ei_req",      32'(ifc.ei_req),         32'h1);
    step(6);                       // E+16: ch0 second hit, ch1 hit at E+12/E+15
    check_eq("t6_ovr_pre",     32'(ifc.irq_overrun),    32'h3);
    check_eq("t6_ei_pre",      32'(ifc.ei_req),         32'h1);

    // Reset mid-count: outputs drop at once; full P+1 after re-enable.
    step(3);
    resetb = 1'b0;
    #1;
    check_eq("t6_rst_pend",    32'(ifc.irq_pending),    32'h0);
    check_eq("t6_rst_ovr",     32'(ifc.irq_overrun),    32'h0);
    check_eq("t6_rst_ei",      32'(ifc.ei_req),         32'h0);
    step(2);
    resetb = 1'b1;
    step(1);                       // E'': enable registered
    step(7);
    check_eq("t6_pend_before", 32'(ifc.irq_pending),    32'h2);
    step(1);
    check_eq("t6_pend_hit",    32'(ifc.irq_pending),    32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yrv_tick_irq.md
Name: yrv_tick_irq

Overview:
- Multi-channel periodic interrupt timer for the yrv_mcu board tops.
- Generalises the fixed 125 Hz tick latch into N_CH independent channels.
- Each channel has a programmable period, a periodic or one-shot mode, a sticky pending flag, an overrun flag and a mask.
- A shared programmable prescaler feeds all channels; the registered OR of masked pending flags drives the MCU ei_req input.

Parameters:
- N_CH, 4: number of timer channels.
- CNT_W, 16: width of each channel counter and period value.
- PRE_W, 16: width of the shared prescaler.

Ports:
- clk  input  1  system clock.
- resetb  input  1  reset, asynchronous, active-low.
- prescale_div  input  PRE_W  prescaler terminal count; one tick every prescale_div+1 clk cycles.
- ch_en  input  N_CH  per-channel enable, level.
- ch_oneshot  input  N_CH  1 = one-shot, 0 = periodic.
- ch_period  input  N_CH*CNT_W  per-channel terminal count; channel i occupies bits [i*CNT_W +: CNT_W].
- ch_ack  input  N_CH  per-channel clear of pending/overrun, level (the existing port3_reg[15] style clear).
- irq_mask  input  N_CH  1 = channel contributes to ei_req.
- irq_pending  output  N_CH  sticky event flag per channel.
- irq_overrun  output  N_CH  event occurred while pending was still set.
- ei_req  output  1  registered OR of irq_pending & irq_mask.

Behaviour:
- Reset: every register is cleared asynchronously while resetb=0. This includes the prescaler count, channel counts and channel states (IDLE), irq_pending, irq_overrun and ei_req.
- Reset asserted mid-count discards all progress. Outputs are 0 from the assertion onward.
- Prescaler:
  - pre_cnt is free-running.
  - tick=1 in a cycle where pre_cnt >= prescale_div; pre_cnt then loads 0, otherwise it increments.
  - prescale_div=0 gives tick every cycle.
  - The >= compare makes a reduced prescale_div take effect without waiting for a wrap.
- Channel state machine (per channel):
  - IDLE: cnt=0, no events. Moves to RUN at the first edge with ch_en=1.
  - RUN: on tick, hit = (cnt >= period). If hit, cnt loads 0; otherwise cnt increments. Without tick, cnt holds. hit is only evaluated on tick cycles.
    - Periodic mode: stays in RUN after a hit.
    - One-shot mode: moves to DONE after a hit.
  - DONE: cnt holds, no further hits.
  - Any state: ch_en=0 returns the channel to IDLE at the next edge (cnt=0). A channel in DONE must pass through IDLE to re-arm.
- Mode and period are sampled every cycle. A new period applies to the current count; if cnt >= new period, the hit fires on the next tick.
- Timing, prescale_div=0, period=P, enable registered at edge E:
  - First hit is evaluated at edge E+P+1; irq_pending=1 after that edge.
  - ei_req=1 one edge later (E+P+2).
  - Periodic hits then repeat every P+1 ticks.
  - period=0 hits on every tick.
- Pending/overrun, per channel, at each edge:
  - hit=1: pending <= 1. overrun <= 1 if pending was already 1 and ch_ack=0; otherwise overrun <= 0 if ch_ack=1, else it holds.
  - hit=0, ch_ack=1: pending <= 0, overrun <= 0.
  - hit=0, ch_ack=0: both hold.
  - Simultaneous hit and ack: the new event wins (pending=1), overrun cleared; no event is lost.
  - Disabling a channel does not clear its flags; only ch_ack or reset clears them.
- ei_req <= |(irq_pending & irq_mask), registered, so there is one cycle of latency from a pending or mask change.
  - Masking does not affect irq_pending or irq_overrun.
- Counter width: cnt compare and increment are CNT_W bits. Because of the >= compare, cnt never exceeds the period once it is reached, so there is no wrap-around.

Test Plan:
- 125 Hz compatibility: N_CH=1, prescale_div=0, period=39999, periodic, mask=1, ack low, reset released → pending rises 40000 cycles after the enable edge; ei_req follows 1 cycle later; overrun=1 at the second hit (80000 cycles).
- Prescaled periodic plus ack: prescale_div=4, period=9 → hits every 50 clk cycles. Pulse ch_ack for 1 cycle between hits → pending clears, re-sets at the next hit, overrun stays 0.
- Simultaneous hit and ack: ch_ack held high across a hit edge (period=3, prescale_div=0) → pending=1 at that edge, overrun=0; pending clears the cycle after the hit once ack is seen without a hit.
- One-shot: period=5, oneshot=1 → exactly one hit 6 cycles after enable, no hit over the next 100 cycles. Drop ch_en for 1 cycle then reassert → hit again 6 cycles after re-enable.
- Multi-channel mask and period shrink: ch0 period=7, ch1 period=11, mask=2'b10 → ei_req only after ch1 pending. Reduce ch1 period from 11 to 2 while cnt=8 → hit on the next tick.
- Reset mid-operation: assert resetb=0 with pending, overrun and ei_req all 1 and cnt mid-count → all outputs 0 immediately; after release, first hit occurs a full P+1 cycles after re-enable.
